axi_sram_slave: RTL and testbench

// AXI4 responder (slave) that serves the CPU-side AXI4 master's fetch and load/store traffic from an internal word-wide SRAM.
// - Independent read and write channel FSMs.
// - At most one outstanding transaction per direction.
// - Programmable response latency, so the master's wait states can be exercised in simulation.
// - Sits at the far end of io_master_*: connect io_slave_* port-for-port.

---
 rtl/axi_pkg.sv | 27 ++
 rtl/axi_sram_mem.sv | 32 +++
 rtl/axi_sram_slave.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM responder: response and burst codes,
// channel FSM state encodings and small per-beat helpers.
package axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  // Width of the response latency counters.
  localparam int LAT_W = 16;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wr_state_e;

  // Byte increment between consecutive beats of an INCR burst.
  function automatic logic [31:0] beat_bytes(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

  // Transfers wider than the 32-bit data path or non-INCR bursts are refused.
  function automatic logic unsupported(input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'd2) || (burst != AXI_BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// Word-wide 1R1W synchronous SRAM with byte-lane write enables.
// Ports: clock; re/raddr/rdata read port (rdata registered, updated only
// when re is high, so it holds while the reader stalls); we/waddr/wdata/wstrb
// write port. A read and write of the same word on one edge returns the old data.
module axi_sram_mem #(
  parameter int WORDS = 65536,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb
);

  // One byte-wide array per lane keeps each lane a plain inferred RAM.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_q [WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge clock) begin
      if (we && wstrb[gi]) lane_q[waddr] <= wdata[gi*8 +: 8];
      if (re) rd_q <= lane_q[raddr];
    end

    assign rdata[gi*8 +: 8] = rd_q;
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 responder serving a word-wide internal SRAM.
// Ports: clock/reset (sync, active high); io_slave_aw* write address,
// io_slave_w* write data, io_slave_b* write response, io_slave_ar* read
// address, io_slave_r* read data. One outstanding transaction per direction,
// independent read and write FSMs, RD_LAT/WR_LAT programmable response latency.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          WORDS  = 65536,
  parameter int          RD_LAT = 2,
  parameter int          WR_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_slave_awready,
  input  logic        io_slave_awvalid,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  output logic        io_slave_wready,
  input  logic        io_slave_wvalid,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  input  logic        io_slave_bready,
  output logic        io_slave_bvalid,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  output logic        io_slave_arready,
  input  logic        io_slave_arvalid,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  input  logic        io_slave_rready,
  output logic        io_slave_rvalid,
  output logic [1:0]  io_slave_rresp,
  output logic [31:0] io_slave_rdata,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  localparam int AW = $clog2(WORDS);

  // Per-beat decode; the address is re-decoded every beat so a burst running
  // off the end of the SRAM turns into DECERR from the crossing beat onward.
  function automatic logic [1:0] decode(input logic [31:0] addr, input logic err);
    if (err) return AXI_RESP_SLVERR;
    if (((addr - BASE) >> 2) < 32'(WORDS)) return AXI_RESP_OKAY;
    return AXI_RESP_DECERR;
  endfunction

  function automatic logic [AW-1:0] word_index(input logic [31:0] addr);
    return AW'((addr - BASE) >> 2);
  endfunction

  // Read channel state
  rd_state_e         rd_state_q, rd_state_d;
  logic [31:0]       rd_addr_q, rd_addr_d, rd_next_addr;
  logic [7:0]        rd_len_q, rd_len_d, rd_beat_q, rd_beat_d;
  logic [2:0]        rd_size_q, rd_size_d;
  logic [3:0]        rd_id_q, rd_id_d;
  logic              rd_err_q, rd_err_d;
  logic [LAT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;

  // Write channel state
  wr_state_e         wr_state_q, wr_state_d;
  logic [31:0]       wr_addr_q, wr_addr_d;
  logic [7:0]        wr_len_q, wr_len_d;
  logic [8:0]        wr_beat_q, wr_beat_d;
  logic [2:0]        wr_size_q, wr_size_d;
  logic [3:0]        wr_id_q, wr_id_d;
  logic              wr_err_q, wr_err_d, wr_dec_q, wr_dec_d;
  logic [LAT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [1:0]        wr_beat_resp;
  logic              wr_in_burst;

  // SRAM port signals
  logic              mem_re, mem_we;
  logic [AW-1:0]     mem_raddr, mem_waddr;
  logic [31:0]       mem_rdata, mem_wdata;
  logic [3:0]        mem_wstrb;

  axi_sram_mem #(.WORDS(WORDS)) u_mem (
    .clock (clock),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .wstrb (mem_wstrb)
  );

  // Read FSM. The SRAM read for a beat is issued on the cycle before it is
  // shown, so the next beat follows a handshake with no bubble.
  always_comb begin
    rd_state_d       = rd_state_q;
    rd_addr_d        = rd_addr_q;
    rd_len_d         = rd_len_q;
    rd_size_d        = rd_size_q;
    rd_id_d          = rd_id_q;
    rd_err_d         = rd_err_q;
    rd_cnt_d         = rd_cnt_q;
    rd_beat_d        = rd_beat_q;
    rvalid_d         = rvalid_q;
    rresp_d          = rresp_q;
    io_slave_arready = 1'b0;
    mem_re           = 1'b0;
    mem_raddr        = word_index(rd_addr_q);
    rd_next_addr     = rd_addr_q + beat_bytes(rd_size_q);
    case (rd_state_q)
      R_IDLE: begin
        io_slave_arready = 1'b1;
        if (io_slave_arvalid) begin
          rd_addr_d  = io_slave_araddr;
          rd_len_d   = io_slave_arlen;
          rd_size_d  = io_slave_arsize;
          rd_id_d    = io_slave_arid;
          rd_err_d   = unsupported(io_slave_arsize, io_slave_arburst);
          rd_cnt_d   = LAT_W'(RD_LAT - 1);
          rd_beat_d  = 8'd0;
          rd_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rd_cnt_q == '0) begin
          rresp_d    = decode(rd_addr_q, rd_err_q);
          mem_re     = (rresp_d == AXI_RESP_OKAY);
          rvalid_d   = 1'b1;
          rd_state_d = R_DATA;
        end else begin
          rd_cnt_d = rd_cnt_q - LAT_W'(1);
        end
      end
      R_DATA: begin
        if (io_slave_rready) begin
          if (rd_beat_q == rd_len_q) begin
            rvalid_d   = 1'b0;
            rd_state_d = R_IDLE;
          end else begin
            rd_addr_d = rd_next_addr;
            rd_beat_d = rd_beat_q + 8'd1;
            rresp_d   = decode(rd_next_addr, rd_err_q);
            mem_re    = (rresp_d == AXI_RESP_OKAY);
            mem_raddr = word_index(rd_next_addr);
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write FSM. Beats beyond awlen+1 are absorbed without touching the SRAM;
  // the response becomes SLVERR if wlast disagrees with awlen.
  always_comb begin
    wr_state_d       = wr_state_q;
    wr_addr_d        = wr_addr_q;
    wr_len_d         = wr_len_q;
    wr_size_d        = wr_size_q;
    wr_id_d          = wr_id_q;
    wr_err_d         = wr_err_q;
    wr_dec_d         = wr_dec_q;
    wr_beat_d        = wr_beat_q;
    wr_cnt_d         = wr_cnt_q;
    bvalid_d         = bvalid_q;
    bresp_d          = bresp_q;
    io_slave_awready = 1'b0;
    io_slave_wready  = 1'b0;
    mem_we           = 1'b0;
    mem_waddr        = word_index(wr_addr_q);
    mem_wdata        = io_slave_wdata;
    mem_wstrb        = io_slave_wstrb;
    wr_beat_resp     = decode(wr_addr_q, wr_err_q);
    wr_in_burst      = (wr_beat_q <= {1'b0, wr_len_q});
    case (wr_state_q)
      W_IDLE: begin
        io_slave_awready = 1'b1;
        if (io_slave_awvalid) begin
          wr_addr_d  = io_slave_awaddr;
          wr_len_d   = io_slave_awlen;
          wr_size_d  = io_slave_awsize;
          wr_id_d    = io_slave_awid;
          wr_err_d   = unsupported(io_slave_awsize, io_slave_awburst);
          wr_dec_d   = 1'b0;
          wr_beat_d  = 9'd0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        io_slave_wready = 1'b1;
        if (io_slave_wvalid) begin
          if (wr_in_burst) begin
            mem_we = (wr_beat_resp == AXI_RESP_OKAY);
            if (wr_beat_resp == AXI_RESP_DECERR) wr_dec_d = 1'b1;
            wr_addr_d = wr_addr_q + beat_bytes(wr_size_q);
          end
          // Saturate so a runaway burst can never wrap back to a matching count.
          if (wr_beat_q != 9'h1FF) wr_beat_d = wr_beat_q + 9'd1;
          if (io_slave_wlast) begin
            if (wr_err_q || (wr_beat_q != {1'b0, wr_len_q})) bresp_d = AXI_RESP_SLVERR;
            else if (wr_dec_d)                              bresp_d = AXI_RESP_DECERR;
            else                                            bresp_d = AXI_RESP_OKAY;
            wr_cnt_d   = LAT_W'(WR_LAT - 1);
            wr_state_d = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (wr_cnt_q == '0) begin
          bvalid_d   = 1'b1;
          wr_state_d = W_RESP;
        end else begin
          wr_cnt_d = wr_cnt_q - LAT_W'(1);
        end
      end
      W_RESP: begin
        if (io_slave_bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_size_q  <= '0;
      rd_id_q    <= '0;
      rd_err_q   <= 1'b0;
      rd_cnt_q   <= '0;
      rd_beat_q  <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= AXI_RESP_OKAY;
      wr_state_q <= W_IDLE;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_size_q  <= '0;
      wr_id_q    <= '0;
      wr_err_q   <= 1'b0;
      wr_dec_q   <= 1'b0;
      wr_beat_q  <= '0;
      wr_cnt_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= AXI_RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      rd_size_q  <= rd_size_d;
      rd_id_q    <= rd_id_d;
      rd_err_q   <= rd_err_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_beat_q  <= rd_beat_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
      wr_size_q  <= wr_size_d;
      wr_id_q    <= wr_id_d;
      wr_err_q   <= wr_err_d;
      wr_dec_q   <= wr_dec_d;
      wr_beat_q  <= wr_beat_d;
      wr_cnt_q   <= wr_cnt_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  assign io_slave_rvalid = rvalid_q;
  assign io_slave_rresp  = rresp_q;
  assign io_slave_rid    = rd_id_q;
  assign io_slave_rlast  = rvalid_q && (rd_beat_q == rd_len_q);
  // Error beats and idle cycles show zero instead of whatever the SRAM holds.
  assign io_slave_rdata  = (rvalid_q && (rresp_q == AXI_RESP_OKAY)) ? mem_rdata : 32'd0;
  assign io_slave_bvalid = bvalid_q;
  assign io_slave_bresp  = bresp_q;
  assign io_slave_bid    = wr_id_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: stimulus pushes expected R/B responses
// into queues; a monitor pops and compares whenever a response handshakes.
module tb_axi_sram_slave;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        awready, awvalid, wready, wvalid, wlast, bready, bvalid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, wstrb, bid, arid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        arready, arvalid, rready, rvalid, rlast;
  logic        rr_toggle = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } r_exp_t;
  typedef struct { logic [1:0] resp; logic [3:0] id; } b_exp_t;
  r_exp_t rq[$];
  b_exp_t bq[$];

  always #5 clock = ~clock;

  axi_sram_slave #(.BASE(BASE), .WORDS(65536), .RD_LAT(2), .WR_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .io_slave_awready(awready), .io_slave_awvalid(awvalid), .io_slave_awaddr(awaddr),
    .io_slave_awid(awid), .io_slave_awlen(awlen), .io_slave_awsize(awsize),
    .io_slave_awburst(awburst),
    .io_slave_wready(wready), .io_slave_wvalid(wvalid), .io_slave_wdata(wdata),
    .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
    .io_slave_bready(bready), .io_slave_bvalid(bvalid), .io_slave_bresp(bresp),
    .io_slave_bid(bid),
    .io_slave_arready(arready), .io_slave_arvalid(arvalid), .io_slave_araddr(araddr),
    .io_slave_arid(arid), .io_slave_arlen(arlen), .io_slave_arsize(arsize),
    .io_slave_arburst(arburst),
    .io_slave_rready(rready), .io_slave_rvalid(rvalid), .io_slave_rresp(rresp),
    .io_slave_rdata(rdata), .io_slave_rlast(rlast), .io_slave_rid(rid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: handshake never happened, expected within 100 cycles", name);
  endtask

  task automatic push_r(input logic [31:0] d, input logic [1:0] resp, input logic last, input logic [3:0] id);
    r_exp_t e;
    e.data = d; e.resp = resp; e.last = last; e.id = id;
    rq.push_back(e);
  endtask

  task automatic push_b(input logic [1:0] resp, input logic [3:0] id);
    b_exp_t e;
    e.resp = resp; e.id = id;
    bq.push_back(e);
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic ar_send(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    int t = 0;
    arvalid = 1'b1; araddr = a; arlen = len; arsize = size; arburst = burst; arid = id;
    do begin @(negedge clock); t++; end while (!arready && t < 100);
    @(posedge clock); #1;
    if (t >= 100) timeout("ar_handshake");
    arvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    int t = 0;
    awvalid = 1'b1; awaddr = a; awlen = len; awsize = size; awburst = burst; awid = id;
    do begin @(negedge clock); t++; end while (!awready && t < 100);
    @(posedge clock); #1;
    if (t >= 100) timeout("aw_handshake");
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] strb, input logic last);
    int t = 0;
    wvalid = 1'b1; wdata = d; wstrb = strb; wlast = last;
    do begin @(negedge clock); t++; end while (!wready && t < 100);
    @(posedge clock); #1;
    if (t >= 100) timeout("w_handshake");
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((rq.size() != 0 || bq.size() != 0) && t < 200) begin @(posedge clock); t++; end
    #1;
    if (rq.size() != 0 || bq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL response_timeout: pending r=%0d b=%0d expected 0", rq.size(), bq.size());
      rq.delete();
      bq.delete();
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb,
                          input logic [2:0] size, input logic [3:0] id, input logic [1:0] resp);
    push_b(resp, id);
    aw_send(a, 8'd0, size, 2'b01, id);
    w_send(d, strb, 1'b1);
    wait_done();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [31:0] d,
                         input logic [1:0] resp);
    push_r(d, resp, 1'b1, id);
    ar_send(a, 8'd0, 3'd2, 2'b01, id);
    wait_done();
  endtask

  // rready: held high, or toggling each cycle while rr_toggle is set.
  initial begin
    rready = 1'b1;
    forever begin
      @(posedge clock); #1;
      rready = rr_toggle ? ~rready : 1'b1;
    end
  end

  // Monitor: compares every presented R beat (including stalled cycles, which
  // proves data is held) and every B response against the queue heads.
  initial begin : monitor
    r_exp_t re;
    b_exp_t be;
    forever begin
      @(negedge clock);
      if (!reset && rvalid) begin
        if (rq.size() == 0) begin
          check("r_unexpected_rvalid", 32'(rvalid), 32'd0);
        end else begin
          re = rq[0];
          check("rdata", rdata, re.data);
          check("rresp", 32'(rresp), 32'(re.resp));
          check("rlast", 32'(rlast), 32'(re.last));
          check("rid", 32'(rid), 32'(re.id));
          if (rready) begin
            $display("R beat id=%0d data=%h resp=%0d last=%0b", rid, rdata, rresp, rlast);
            void'(rq.pop_front());
          end
        end
      end
      if (!reset && bvalid) begin
        if (bq.size() == 0) begin
          check("b_unexpected_bvalid", 32'(bvalid), 32'd0);
        end else begin
          be = bq[0];
          check("bresp", 32'(bresp), 32'(be.resp));
          check("bid", 32'(bid), 32'(be.id));
          if (bready) begin
            $display("B resp id=%0d resp=%0d", bid, bresp);
            void'(bq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 1'b1;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset values
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_wready",  32'(wready),  32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_rlast",   32'(rlast),   32'd0);
    check("rst_rresp",   32'(rresp),   32'd0);
    check("rst_bresp",   32'(bresp),   32'd0);
    check("rst_rid",     32'(rid),     32'd0);
    check("rst_bid",     32'(bid),     32'd0);
    check("rst_rdata",   rdata,        32'd0);

    // Single read with latency check: mem[1]=DEADBEEF
    do_write(BASE + 32'd4, 32'hDEADBEEF, 4'hF, 3'd2, 4'd3, 2'b00);
    push_r(32'hDEADBEEF, 2'b00, 1'b1, 4'd5);
    ar_send(BASE + 32'd4, 8'd0, 3'd2, 2'b01, 4'd5);
    @(posedge clock); #1;
    check("rd_lat_cycle1_rvalid", 32'(rvalid), 32'd0);
    @(posedge clock); #1;
    check("rd_lat_cycle2_rvalid", 32'(rvalid), 32'd1);
    wait_done();

    // Byte-lane write over a zero word
    do_write(BASE + 32'd8, 32'h0000_0000, 4'hF, 3'd2, 4'd1, 2'b00);
    do_write(BASE + 32'd8, 32'h1122_3344, 4'b0010, 3'd2, 4'd1, 2'b00);
    do_read(BASE + 32'd8, 4'd1, 32'h0000_3300, 2'b00);

    // Burst write of words 4..7, then burst read with rready toggling
    push_b(2'b00, 4'd7);
    aw_send(BASE + 32'd16, 8'd3, 3'd2, 2'b01, 4'd7);
    for (int i = 0; i < 4; i++) w_send(32'hA000_0000 + 32'(i), 4'hF, i == 3);
    wait_done();
    for (int i = 0; i < 4; i++) push_r(32'hA000_0000 + 32'(i), 2'b00, i == 3, 4'd6);
    rr_toggle = 1'b1;
    ar_send(BASE + 32'd16, 8'd3, 3'd2, 2'b01, 4'd6);
    wait_done();
    rr_toggle = 1'b0;

    // Out-of-range read
    do_read(32'h0000_0000, 4'd2, 32'h0000_0000, 2'b11);

    // Unsupported size on write: SLVERR and memory untouched
    do_write(BASE + 32'd4, 32'hFFFF_FFFF, 4'hF, 3'd3, 4'd9, 2'b10);
    do_read(BASE + 32'd4, 4'd9, 32'hDEADBEEF, 2'b00);

    // len=1 write terminated early by wlast: SLVERR, first beat still written
    push_b(2'b10, 4'd4);
    aw_send(BASE + 32'd12, 8'd1, 3'd2, 2'b01, 4'd4);
    w_send(32'h0000_0055, 4'hF, 1'b1);
    wait_done();
    do_read(BASE + 32'd12, 4'd4, 32'h0000_0055, 2'b00);

    // Same-cycle AR/AW to word 9; W lands on the SRAM read edge -> old data
    do_write(BASE + 32'd36, 32'h1111_1111, 4'hF, 3'd2, 4'd2, 2'b00);
    push_b(2'b00, 4'd2);
    push_r(32'h1111_1111, 2'b00, 1'b1, 4'd4);
    fork
      ar_send(BASE + 32'd36, 8'd0, 3'd2, 2'b01, 4'd4);
      aw_send(BASE + 32'd36, 8'd0, 3'd2, 2'b01, 4'd2);
    join
    @(posedge clock); #1;
    w_send(32'h2222_2222, 4'hF, 1'b1);
    wait_done();

    // Same-cycle AR/AW; W one cycle before the SRAM read -> new data
    push_b(2'b00, 4'd8);
    push_r(32'h3333_3333, 2'b00, 1'b1, 4'd11);
    fork
      ar_send(BASE + 32'd36, 8'd0, 3'd2, 2'b01, 4'd11);
      aw_send(BASE + 32'd36, 8'd0, 3'd2, 2'b01, 4'd8);
    join
    w_send(32'h3333_3333, 4'hF, 1'b1);
    wait_done();

    // Reset during R_WAIT aborts the read with no response
    ar_send(BASE + 32'd4, 8'd0, 3'd2, 2'b01, 4'd12);
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst_mid_rvalid", 32'(rvalid), 32'd0);
    check("rst_mid_arready", 32'(arready), 32'd1);
    reset = 1'b0;
    @(posedge clock); #1;
    check("rst_mid_rvalid_later", 32'(rvalid), 32'd0);
    check("rst_mid_rid", 32'(rid), 32'd0);
    do_read(BASE + 32'd4, 4'd13, 32'hDEADBEEF, 2'b00);

    repeat (3) @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
